fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction queue entry count (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-high (asserted when 1), despite the name.
REQ-005 req_valid_o  output  1  SHALL indicate a fetch request to instruction memory.
REQ-006 req_addr_o  output  32  SHALL carry the fetch address; bits [1:0] always 0.
REQ-007 req_ready_i  input  1  SHALL indicate memory accepts the request this cycle.
REQ-008 rsp_valid_i  input  1  SHALL indicate rsp_data_i holds the instruction for the outstanding request.
REQ-009 rsp_data_i  input  32  SHALL carry the fetched instruction word.
REQ-010 redirect_i  input  1  SHALL request a flush and restart at redirect_pc_i.
REQ-011 redirect_pc_i  input  32  SHALL carry the new fetch address; bits [1:0] ignored (forced 0).
REQ-012 hold_i  input  1  SHALL suppress new fetch requests while 1.
REQ-013 out_valid_o  output  1  SHALL indicate the queue head is valid to decode.
REQ-014 out_pc_o  output  32  SHALL carry the head entry PC.
REQ-015 out_inst_o  output  32  SHALL carry the head entry instruction.
REQ-016 out_ready_i  input  1  SHALL indicate decode consumes the head this cycle.
REQ-017 count_o  output  $clog2(DEPTH)+1  SHALL report occupied queue entries.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-019 IDLE->REQ when !hold_i and count_o + (response pending) < DEPTH; req_valid_o=1 only in REQ.
REQ-020 In REQ, req_addr_o SHALL equal fetch_pc and stay stable until req_valid_o&&req_ready_i; hold_i SHALL NOT retract an asserted request.
REQ-021 On acceptance: pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), REQ->WAIT.
REQ-022 In WAIT, rsp_valid_i SHALL push {pending_pc, rsp_data_i} at the tail and move to REQ if credit and !hold_i, else IDLE; same-cycle re-request allowed only from the next cycle.
REQ-023 rsp_valid_i outside WAIT/DROP SHALL be ignored.
REQ-024 Push and pop in the same cycle SHALL both occur, count_o unchanged; pop only when out_valid_o&&out_ready_i.
REQ-025 Queue SHALL never overflow: credit rule (REQ-019) reserves space before request issue.
REQ-026 out_valid_o = (count_o != 0); no bypass: a response at edge N appears on out_* after edge N.
REQ-027 redirect_i SHALL take priority over all events: queue emptied (count_o<=0), fetch_pc<=redirect_pc_i, same-cycle pop/push discarded.
REQ-028 redirect_i in WAIT (response not arriving that cycle) SHALL go to DROP; DROP discards the next rsp_valid_i then goes to IDLE.
REQ-029 redirect_i in REQ SHALL withdraw to IDLE if not accepted that cycle; if accepted the same cycle, go to DROP.
REQ-030 redirect_i in DROP SHALL update fetch_pc and remain in DROP.
REQ-031 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 While rst_n=1: state IDLE, fetch_pc=RESET_PC, queue empty, req_valid_o=0, out_valid_o=0, count_o=0, req_addr_o=RESET_PC, out_pc_o=0, out_inst_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding request; a later rsp_valid_i in IDLE is ignored.
REQ-034 First req_valid_o SHALL assert after the first clk edge following rst_n deassert (hold_i=0).

Verification
REQ-035 Reset release, req_ready_i=1, rsp 1 cycle later with 32'h0000_0013, out_ready_i=0 -> addresses 0,4,8,C; count_o reaches 4; no 5th request.
REQ-036 Full queue, out_ready_i=1 one cycle -> head pc 0/inst popped, count_o 3, new request at 0x10.
REQ-037 redirect_i with redirect_pc_i=32'h0000_0103 while in WAIT -> queue empty, response dropped, next request addr 0x100.
REQ-038 req_ready_i=0 for 5 cycles with hold_i pulsed -> req_valid_o held, req_addr_o stable.
REQ-039 fetch_pc=32'hFFFF_FFFC accepted -> next req_addr_o 32'h0000_0000.
REQ-040 Reset asserted in WAIT, rsp_valid_i after deassert -> ignored, count_o stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetcher feeding a credit-protected FIFO to decode
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     req_valid_o,
   output logic [31:0]              req_addr_o,
   input  logic                     req_ready_i,
   input  logic                     rsp_valid_i,
   input  logic [31:0]              rsp_data_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   input  logic                     hold_i,
   output logic                     out_valid_o,
   output logic [31:0]              out_pc_o,
   output logic [31:0]              out_inst_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
   state_t state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, pending_pc_q, pending_pc_d;
   logic [31:0] pc_q [DEPTH];
   logic [31:0] pc_d [DEPTH];
   logic [31:0] inst_q [DEPTH];
   logic [31:0] inst_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic push, pop;
   // state and datapath registers; reset abandons any outstanding request
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= IDLE;
         fetch_pc_q   <= BOOT_PC;
         pending_pc_q <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
      end
   end
   // queue and fetch-address updates; a redirect overrides every other event
   always_comb begin
      push         = state_q == WAIT && rsp_valid_i && !redirect_i;
      pop          = count_q != '0 && out_ready_i && !redirect_i;
      pc_d         = pc_q;
      inst_d       = inst_q;
      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      pending_pc_d = state_q == REQ && req_ready_i ? fetch_pc_q : pending_pc_q;
      fetch_pc_d   = state_q == REQ && req_ready_i ? fetch_pc_q + 32'd4 : fetch_pc_q;
      if (push) begin
         pc_d[wr_ptr_q]   = pending_pc_q;
         inst_d[wr_ptr_q] = rsp_data_i;
      end
      if (redirect_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      end
   end
   // next state: requests only issue when the queue has room for their response
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !redirect_i && !hold_i && count_q < FULL ? REQ : IDLE;
         REQ:     state_d = req_ready_i ? (redirect_i ? DROP : WAIT) : (redirect_i ? IDLE : REQ);
         WAIT:    state_d = redirect_i ? (rsp_valid_i ? IDLE : DROP)
                          : !rsp_valid_i ? WAIT : !hold_i && count_d < FULL ? REQ : IDLE;
         DROP:    state_d = rsp_valid_i ? IDLE : DROP;
         default: state_d = IDLE;
      endcase
   end
   // outputs: head fields read as zero while the queue is empty
   always_comb begin
      req_valid_o = state_q == REQ;
      req_addr_o  = fetch_pc_q;
      out_valid_o = count_q != '0;
      out_pc_o    = out_valid_o ? pc_q[rd_ptr_q] : '0;
      out_inst_o  = out_valid_o ? inst_q[rd_ptr_q] : '0;
      count_o     = count_q;
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized run against a queue-based reference model
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic req_valid_o, req_ready_i = 1'b0;
   logic [31:0] req_addr_o;
   logic rsp_valid_i = 1'b0;
   logic [31:0] rsp_data_i = '0;
   logic redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic hold_i = 1'b0;
   logic out_valid_o, out_ready_i = 1'b0;
   logic [31:0] out_pc_o, out_inst_o;
   logic [2:0] count_o;
   int vectors = 0;
   int miscompares = 0;
   typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
   ent_t mq[$];
   bit m_req, m_out, m_drop;
   logic [31:0] m_pc, m_pend;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
      .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .hold_i(hold_i),
      .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
      .out_ready_i(out_ready_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      mq.delete();
      m_req = 0;
      m_out = 0;
      m_drop = 0;
      m_pc = RESET_PC & 32'hFFFF_FFFC;
      m_pend = '0;
   endfunction

   // m_req: request on the bus; m_out: a response is owed and kept; m_drop: owed but discarded
   function automatic void model_step();
      int sz;
      bit do_pop;
      if (redirect_i) begin
         if (m_req) begin
            m_drop = req_ready_i;
            m_req = 0;
         end else if (m_out) begin
            m_drop = !rsp_valid_i;
            m_out = 0;
         end else if (m_drop && rsp_valid_i) m_drop = 0;
         mq.delete();
         m_pc = redirect_pc_i & 32'hFFFF_FFFC;
         return;
      end
      sz = mq.size();
      do_pop = sz != 0 && out_ready_i;
      if (m_req) begin
         if (req_ready_i) begin
            m_pend = m_pc;
            m_pc = m_pc + 32'd4;
            m_req = 0;
            m_out = 1;
         end
      end else if (m_out) begin
         if (rsp_valid_i) begin
            mq.push_back({m_pend, rsp_data_i});
            m_out = 0;
            m_req = !hold_i && (sz + 1 - int'(do_pop)) < DEPTH;
         end
      end else if (m_drop) begin
         if (rsp_valid_i) m_drop = 0;
      end else m_req = !hold_i && sz < DEPTH;
      if (do_pop) void'(mq.pop_front());
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset req_valid: got %b want 0", req_valid_o); end
      vectors++; if (req_addr_o !== RESET_PC) begin miscompares++; $display("FAIL reset req_addr: got %h want %h", req_addr_o, RESET_PC); end
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", out_valid_o); end
      vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", count_o); end
      vectors++; if (out_pc_o !== 32'h0) begin miscompares++; $display("FAIL reset out_pc: got %h want 0", out_pc_o); end
      vectors++; if (out_inst_o !== 32'h0) begin miscompares++; $display("FAIL reset out_inst: got %h want 0", out_inst_o); end
   endtask

   task automatic test_fill();
      logic [31:0] addrs[$];
      logic [31:0] exp_a;
      rst_n = 1'b0;
      req_ready_i = 1'b1;
      rsp_valid_i = 1'b1;
      rsp_data_i = 32'h0000_0013;
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL first_req_early: got %b want 0", req_valid_o); end
      tick();
      vectors++; if (req_valid_o !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", req_valid_o); end
      for (int i = 0; i < 20; i++) begin
         if (req_valid_o && req_ready_i) addrs.push_back(req_addr_o);
         tick();
      end
      vectors++; if (addrs.size() != 4) begin miscompares++; $display("FAIL fill_req_count: got %0d want 4", addrs.size()); end
      for (int i = 0; i < 4 && i < addrs.size(); i++) begin
         exp_a = 32'(i * 4);
         vectors++; if (addrs[i] !== exp_a) begin miscompares++; $display("FAIL fill_addr%0d: got %h want %h", i, addrs[i], exp_a); end
      end
      vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count_o); end
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL fill_no_5th: got %b want 0", req_valid_o); end
   endtask

   task automatic test_pop();
      out_ready_i = 1'b1;
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      vectors++; if (out_pc_o !== 32'h0 || out_inst_o !== 32'h13) begin miscompares++; $display("FAIL pop_head: got %h/%h want 0/13", out_pc_o, out_inst_o); end
      tick();
      out_ready_i = 1'b0;
      vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL pop_count: got %0d want 3", count_o); end
      vectors++; if (out_pc_o !== 32'h4) begin miscompares++; $display("FAIL pop_next_head: got %h want 4", out_pc_o); end
      tick();
      vectors++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h10) begin miscompares++; $display("FAIL pop_refetch: got %b/%h want 1/10", req_valid_o, req_addr_o); end
   endtask

   task automatic test_redirect();
      req_ready_i = 1'b1;
      tick();
      req_ready_i = 1'b0;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      tick();
      redirect_i = 1'b0;
      vectors++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin miscompares++; $display("FAIL redirect_flush: got %0d/%b want 0/0", count_o, out_valid_o); end
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL redirect_drop_req: got %b want 0", req_valid_o); end
      rsp_valid_i = 1'b1;
      rsp_data_i = 32'hDEAD_BEEF;
      tick();
      rsp_valid_i = 1'b0;
      vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL redirect_rsp_dropped: got %0d want 0", count_o); end
      tick();
      vectors++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h100) begin miscompares++; $display("FAIL redirect_addr: got %b/%h want 1/100", req_valid_o, req_addr_o); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         hold_i = i[0];
         tick();
         vectors++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h100) begin miscompares++; $display("FAIL stall%0d: got %b/%h want 1/100", i, req_valid_o, req_addr_o); end
      end
      hold_i = 1'b0;
   endtask

   task automatic test_wrap();
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_i = 1'b0;
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL wrap_withdraw: got %b want 0", req_valid_o); end
      tick();
      vectors++; if (req_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffc", req_addr_o); end
      req_ready_i = 1'b1;
      tick();
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b1;
      rsp_data_i = 32'h0000_0055;
      tick();
      rsp_valid_i = 1'b0;
      vectors++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0) begin miscompares++; $display("FAIL wrap_next: got %b/%h want 1/0", req_valid_o, req_addr_o); end
      vectors++; if (count_o !== 3'd1 || out_pc_o !== 32'hFFFF_FFFC || out_inst_o !== 32'h55) begin miscompares++; $display("FAIL wrap_entry: got %0d/%h/%h want 1/fffffffc/55", count_o, out_pc_o, out_inst_o); end
   endtask

   task automatic test_reset_mid();
      req_ready_i = 1'b1;
      tick();
      req_ready_i = 1'b0;
      rst_n = 1'b1;
      #1;
      model_reset();
      vectors++; if (count_o !== 3'd0 || req_valid_o !== 1'b0 || req_addr_o !== RESET_PC) begin miscompares++; $display("FAIL midreset: got %0d/%b/%h want 0/0/%h", count_o, req_valid_o, req_addr_o, RESET_PC); end
      #1;
      rst_n = 1'b0;
      rsp_valid_i = 1'b1;
      rsp_data_i = 32'h0000_0077;
      tick();
      rsp_valid_i = 1'b0;
      vectors++; if (count_o !== 3'd0 || req_valid_o !== 1'b1 || req_addr_o !== RESET_PC) begin miscompares++; $display("FAIL midreset_restart: got %0d/%b/%h want 0/1/%h", count_o, req_valid_o, req_addr_o, RESET_PC); end
   endtask

   task automatic test_random();
      logic [31:0] e_pc, e_inst;
      logic e_valid;
      for (int n = 0; n < 1500; n++) begin
         e_valid = mq.size() != 0;
         e_pc = e_valid ? mq[0].pc : '0;
         e_inst = e_valid ? mq[0].inst : '0;
         vectors++;
         if (req_valid_o !== m_req || req_addr_o !== m_pc || out_valid_o !== e_valid ||
             out_pc_o !== e_pc || out_inst_o !== e_inst || count_o !== 3'(mq.size())) begin
            miscompares++;
            $display("FAIL random cyc%0d: got req=%b addr=%h ov=%b pc=%h inst=%h cnt=%0d want req=%b addr=%h ov=%b pc=%h inst=%h cnt=%0d",
                     n, req_valid_o, req_addr_o, out_valid_o, out_pc_o, out_inst_o, count_o,
                     m_req, m_pc, e_valid, e_pc, e_inst, mq.size());
         end
         hold_i = $urandom_range(3) == 0;
         req_ready_i = $urandom_range(1);
         rsp_valid_i = $urandom_range(1);
         rsp_data_i = $urandom;
         out_ready_i = $urandom_range(2) == 0;
         redirect_i = $urandom_range(19) == 0;
         redirect_pc_i = $urandom;
         tick();
      end
      redirect_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop();
      test_redirect();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
